// File: rtl/capture_channel.sv
// capture_channel: input-capture path for one advanced-timer channel.
// Pin synchronizer, digital glitch filter, polarity edge select, edge
// prescaler, and a capture register with sticky capture/overcapture flags.
module capture_channel #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 pe_gen_clk,
   input  logic                 pe_gen_rstn,
   input  logic                 channel_in,
   input  logic                 r_cce,
   input  logic                 r_ccp,
   input  logic                 r_ccnp,
   input  logic [3:0]           r_icf,
   input  logic [1:0]           r_icpsc,
   input  logic [CNT_WIDTH-1:0] cnt_value,
   input  logic                 capture_clr,
   input  logic                 ovc_clr,
   output logic                 ti_filtered,
   output logic                 ti_edge,
   output logic [CNT_WIDTH-1:0] capture_value,
   output logic                 capture_pulse,
   output logic                 capture_flag,
   output logic                 overcapture_flag
);

   logic       sync_meta;
   logic       s;
   logic [3:0] fcnt;
   logic       ti_filtered_d;
   logic       rise;
   logic       fall;
   logic       q;
   logic [2:0] pcnt;
   logic [2:0] div_m1;
   logic [1:0] psc_q;
   logic       psc_restart;
   logic       fire;

   // Two-flop synchronizer for the asynchronous channel pin.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         sync_meta <= 1'b0;
         s         <= 1'b0;
      end else begin
         sync_meta <= channel_in;
         s         <= sync_meta;
      end
   end

   // Glitch filter: the synchronized level must differ from the filtered
   // level for r_icf+1 consecutive samples before it is accepted. The >=
   // compare keeps the filter from running long if r_icf shrinks mid-count.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         fcnt        <= 4'd0;
         ti_filtered <= 1'b0;
      end else if (s == ti_filtered) begin
         fcnt <= 4'd0;
      end else if (fcnt >= r_icf) begin
         ti_filtered <= s;
         fcnt        <= 4'd0;
      end else begin
         fcnt <= fcnt + 4'd1;
      end
   end

   // Edge detection on the filtered level; ti_edge is unqualified by polarity.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         ti_filtered_d <= 1'b0;
         ti_edge       <= 1'b0;
      end else begin
         ti_filtered_d <= ti_filtered;
         ti_edge       <= rise | fall;
      end
   end

   // Polarity selection, prescaler terminal count and capture decision.
   always_comb begin
      rise = ti_filtered & ~ti_filtered_d;
      fall = ~ti_filtered & ti_filtered_d;
      case ({r_ccnp, r_ccp})
         2'b01:   q = fall;
         2'b11:   q = rise | fall;
         default: q = rise;          // 00 and the reserved 10 both mean rising
      endcase
      case (r_icpsc)
         2'd0:    div_m1 = 3'd0;
         2'd1:    div_m1 = 3'd1;
         2'd2:    div_m1 = 3'd3;
         default: div_m1 = 3'd7;
      endcase
      // A disabled channel or a freshly changed ratio restarts the count;
      // an edge in such a cycle is discarded rather than counted.
      psc_restart = ~r_cce | (r_icpsc != psc_q);
      fire        = q & ~psc_restart & (pcnt == div_m1);
   end

   // Prescaler counter and registered copy of the ratio for change detection.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         pcnt  <= 3'd0;
         psc_q <= 2'd0;
      end else begin
         psc_q <= r_icpsc;
         if (psc_restart) begin
            pcnt <= 3'd0;
         end else if (q) begin
            pcnt <= fire ? 3'd0 : pcnt + 3'd1;
         end
      end
   end

   // Capture register and pulse; the counter is copied raw, wrap is software's job.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         capture_value <= '0;
         capture_pulse <= 1'b0;
      end else begin
         capture_pulse <= fire;
         if (fire) begin
            capture_value <= cnt_value;
         end
      end
   end

   // Sticky flags: a capture wins over a same-cycle clear of either flag.
   always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
      if (!pe_gen_rstn) begin
         capture_flag     <= 1'b0;
         overcapture_flag <= 1'b0;
      end else begin
         if (fire) begin
            capture_flag <= 1'b1;
         end else if (capture_clr) begin
            capture_flag <= 1'b0;
         end
         if (fire && capture_flag && !capture_clr) begin
            overcapture_flag <= 1'b1;
         end else if (ovc_clr) begin
            overcapture_flag <= 1'b0;
         end
      end
   end

endmodule
